// File: rtl/pwm_cmd_pkg.sv
// Shared protocol constants, command codes and FSM state type for the PWM
// command frame controller.
package pwm_cmd_pkg;

    localparam logic [7:0] SOF_BYTE = 8'h4B;
    localparam logic [7:0] EOF_BYTE = 8'h0D;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam logic [7:0] CMD_INIT   = 8'h00;
    localparam logic [7:0] CMD_ENABLE = 8'h02;
    localparam logic [7:0] CMD_INC    = 8'h0A;
    localparam logic [7:0] CMD_DEC    = 8'h12;

    // LEN field carries (payload bytes - 1)
    localparam logic [7:0] LEN_INIT = 8'h00;
    localparam logic [7:0] LEN_MASK = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_EOF,
        ST_EXEC,
        ST_RESP
    } state_t;

    function automatic logic cmd_known(logic [7:0] cmd);
        return (cmd == CMD_INIT) || (cmd == CMD_ENABLE) ||
               (cmd == CMD_INC)  || (cmd == CMD_DEC);
    endfunction

    function automatic logic [7:0] cmd_len(logic [7:0] cmd);
        return (cmd == CMD_INIT) ? LEN_INIT : LEN_MASK;
    endfunction

endpackage

// File: rtl/pwm_cmd_ctrl_if.sv
// UART byte stream and PWM command outputs of pwm_cmd_ctrl, bundled so the
// controller and its environment share one connection point.
interface pwm_cmd_ctrl_if #(
    parameter int g_NUM_CH = 64
);
    logic [7:0]          i_rx_data;
    logic                i_rx_vld;
    logic [7:0]          o_tx_data;
    logic                o_tx_start;
    logic                i_tx_busy;
    logic [g_NUM_CH-1:0] o_en_mask;
    logic [g_NUM_CH-1:0] o_inc_stb;
    logic [g_NUM_CH-1:0] o_dec_stb;
    logic                o_init_vld;
    logic [7:0]          o_init_data;

    modport master (
        output i_rx_data, i_rx_vld, i_tx_busy,
        input  o_tx_data, o_tx_start, o_en_mask, o_inc_stb, o_dec_stb,
               o_init_vld, o_init_data
    );

    modport slave (
        input  i_rx_data, i_rx_vld, i_tx_busy,
        output o_tx_data, o_tx_start, o_en_mask, o_inc_stb, o_dec_stb,
               o_init_vld, o_init_data
    );
endinterface

// File: rtl/frame_timeout.sv
// Inter-byte idle timer: counts cycles without a received byte while a frame
// is open and flags the cycle in which the idle budget runs out.
module frame_timeout #(
    parameter int g_TIMEOUT_CYC = 30000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic kick,
    output logic expired
);
    localparam int CNT_W = $clog2(g_TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] idle_cnt;

    // a byte arriving in the final idle cycle keeps the frame alive
    assign expired = run && !kick && (idle_cnt == CNT_W'(g_TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !run || kick) begin
            idle_cnt <= '0;
        end else if (!expired) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pwm_cmd_ctrl.sv
// UART command frame decoder driving PWM channel enables and inc/dec strobes.
// Optional inter-byte timeout is built only with FRAME_CTRL_TIMEOUT_EN.
//
// state      | meaning
// ST_IDLE    | hunt for SOF, all other bytes dropped
// ST_CMD     | wait for command byte
// ST_LEN     | wait for length byte, checked against command
// ST_PAYLOAD | collect LEN+1 payload bytes, little-endian
// ST_EOF     | wait for frame terminator
// ST_EXEC    | apply command for one cycle, queue ACK
// ST_RESP    | issue queued response once transmitter is free
module pwm_cmd_ctrl
    import pwm_cmd_pkg::*;
#(
    parameter int g_NUM_CH      = 64,
    parameter int g_TIMEOUT_CYC = 30000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    pwm_cmd_ctrl_if.slave bus
);
    localparam int NUM_BYTES = g_NUM_CH / 8;

    if (g_NUM_CH != 8 * (int'(LEN_MASK) + 1)) begin : g_bad_num_ch
        $error("g_NUM_CH must equal 8 x mask payload bytes");
    end
    if (g_TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("g_TIMEOUT_CYC must be at least 1");
    end

    state_t              state, state_nxt;
    logic [7:0]          cmd_q;
    logic [7:0]          len_q;
    logic [7:0]          byte_cnt;
    logic [g_NUM_CH-1:0] payload;
    logic [7:0]          tx_data_q;
    logic [g_NUM_CH-1:0] en_mask_q;
    logic [g_NUM_CH-1:0] inc_q;
    logic [g_NUM_CH-1:0] dec_q;
    logic                init_vld_q;
    logic [7:0]          init_data_q;

    logic       cap_cmd;
    logic       cap_len;
    logic       cap_byte;
    logic       queue_resp;
    logic [7:0] resp_byte;
    logic       exec_now;
    logic       tx_start;
    logic       timeout_hit;

`ifdef FRAME_CTRL_TIMEOUT_EN
    logic frame_open;

    assign frame_open = (state == ST_CMD) || (state == ST_LEN) ||
                        (state == ST_PAYLOAD) || (state == ST_EOF);

    frame_timeout #(
        .g_TIMEOUT_CYC(g_TIMEOUT_CYC)
    ) u_frame_timeout (
        .clk    (i_clk),
        .rst    (i_rst),
        .run    (frame_open),
        .kick   (bus.i_rx_vld),
        .expired(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        cap_cmd    = 1'b0;
        cap_len    = 1'b0;
        cap_byte   = 1'b0;
        queue_resp = 1'b0;
        resp_byte  = NAK_BYTE;
        exec_now   = 1'b0;
        tx_start   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_rx_vld && (bus.i_rx_data == SOF_BYTE)) begin
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (bus.i_rx_vld) begin
                    if (cmd_known(bus.i_rx_data)) begin
                        cap_cmd   = 1'b1;
                        state_nxt = ST_LEN;
                    end else begin
                        queue_resp = 1'b1;
                        state_nxt  = ST_RESP;
                    end
                end
            end
            ST_LEN: begin
                if (bus.i_rx_vld) begin
                    if (bus.i_rx_data == cmd_len(cmd_q)) begin
                        cap_len   = 1'b1;
                        state_nxt = ST_PAYLOAD;
                    end else begin
                        queue_resp = 1'b1;
                        state_nxt  = ST_RESP;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bus.i_rx_vld) begin
                    cap_byte = 1'b1;
                    if (byte_cnt == len_q) begin
                        state_nxt = ST_EOF;
                    end
                end
            end
            ST_EOF: begin
                if (bus.i_rx_vld) begin
                    if (bus.i_rx_data == EOF_BYTE) begin
                        state_nxt = ST_EXEC;
                    end else begin
                        queue_resp = 1'b1;
                        state_nxt  = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                exec_now   = 1'b1;
                queue_resp = 1'b1;
                resp_byte  = ACK_BYTE;
                state_nxt  = ST_RESP;
            end
            ST_RESP: begin
                if (!bus.i_tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // only reachable with no byte present, so nothing captured is lost
        if (timeout_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            len_q       <= '0;
            byte_cnt    <= '0;
            payload     <= '0;
            tx_data_q   <= '0;
            en_mask_q   <= '0;
            inc_q       <= '0;
            dec_q       <= '0;
            init_vld_q  <= 1'b0;
            init_data_q <= '0;
        end else begin
            state      <= state_nxt;
            inc_q      <= '0;
            dec_q      <= '0;
            init_vld_q <= 1'b0;
            if (cap_cmd) begin
                cmd_q <= bus.i_rx_data;
            end
            if (cap_len) begin
                len_q    <= bus.i_rx_data;
                byte_cnt <= '0;
                payload  <= '0;
            end
            if (cap_byte) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (byte_cnt == 8'(i)) begin
                        payload[8*i +: 8] <= bus.i_rx_data;
                    end
                end
                byte_cnt <= byte_cnt + 8'd1;
            end
            if (queue_resp) begin
                tx_data_q <= resp_byte;
            end
            if (exec_now) begin
                case (cmd_q)
                    CMD_ENABLE: en_mask_q <= payload;
                    CMD_INC:    inc_q     <= payload;
                    CMD_DEC:    dec_q     <= payload;
                    CMD_INIT: begin
                        init_data_q <= payload[7:0];
                        init_vld_q  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_tx_start  = tx_start;
    assign bus.o_en_mask   = en_mask_q;
    assign bus.o_inc_stb   = inc_q;
    assign bus.o_dec_stb   = dec_q;
    assign bus.o_init_vld  = init_vld_q;
    assign bus.o_init_data = init_data_q;
endmodule

// File: tb/tb_pwm_cmd_ctrl.sv
// Bench for pwm_cmd_ctrl: directed frames plus randomized frames checked
// against a frame-level reference model; FRAME_CTRL_TIMEOUT_EN selects the timeout case.
module tb_pwm_cmd_ctrl;
    localparam int NCH = 64;
    localparam int TMO = 200;

    localparam int K_NONE = 0;
    localparam int K_EN   = 1;
    localparam int K_INC  = 2;
    localparam int K_DEC  = 3;
    localparam int K_INIT = 4;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          n_send;
        bit          resp;
        logic [7:0]  tx;
        int          kind;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_cmd_ctrl_if #(.g_NUM_CH(NCH)) bus ();

    pwm_cmd_ctrl #(
        .g_NUM_CH     (NCH),
        .g_TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // expected architectural state
    logic [63:0] exp_en   = '0;
    logic [7:0]  exp_init = '0;

    // observation log
    int          cyc = 0;
    int          last_vld_cyc = 0;
    int          stb_cycles = 0;
    int          last_stb_cyc = 0;
    logic [63:0] last_inc = '0;
    logic [63:0] last_dec = '0;
    logic        last_init_vld = 1'b0;
    int          tx_cnt = 0;
    logic [7:0]  last_tx = '0;
    int          busy_viol = 0;
    int          en_chg_cyc = 0;
    logic [63:0] prev_en = '0;

    always @(posedge clk) begin
        cyc++;
        if (bus.i_rx_vld === 1'b1) last_vld_cyc = cyc;
    end

    always @(negedge clk) begin
        if ((|bus.o_inc_stb) || (|bus.o_dec_stb) || bus.o_init_vld) begin
            stb_cycles++;
            last_stb_cyc  = cyc;
            last_inc      = bus.o_inc_stb;
            last_dec      = bus.o_dec_stb;
            last_init_vld = bus.o_init_vld;
        end
        if (bus.o_tx_start === 1'b1) begin
            tx_cnt++;
            last_tx = bus.o_tx_data;
            if (bus.i_tx_busy !== 1'b0) busy_viol++;
        end
        if (bus.o_en_mask !== prev_en) begin
            en_chg_cyc = cyc;
            prev_en    = bus.o_en_mask;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level reference: decides response, bytes consumed and effect.
    function automatic exp_t model(input bq_t fr);
        exp_t       e;
        logic [7:0] want;
        bit         known;
        e.resp   = 1'b1;
        e.tx     = 8'h15;
        e.kind   = K_NONE;
        e.val    = '0;
        e.n_send = fr.size();
        want     = 8'h00;
        known    = 1'b1;
        case (fr[1])
            8'h00:               want = 8'h00;
            8'h02, 8'h0A, 8'h12: want = 8'h07;
            default:             known = 1'b0;
        endcase
        if (!known) begin
            e.n_send = 2;
            return e;
        end
        if (fr[2] != want) begin
            e.n_send = 3;
            return e;
        end
        e.n_send = 5 + int'(want);
        if (fr[e.n_send-1] != 8'h0D) return e;
        for (int i = 0; i <= int'(want); i++) e.val[8*i +: 8] = fr[3+i];
        e.tx = 8'h06;
        case (fr[1])
            8'h00:   e.kind = K_INIT;
            8'h02:   e.kind = K_EN;
            8'h0A:   e.kind = K_INC;
            default: e.kind = K_DEC;
        endcase
        return e;
    endfunction

    function automatic bq_t mask_frame(input logic [7:0] cmd, input logic [63:0] m,
                                       input logic [7:0] eof);
        bq_t q;
        q = {8'h4B, cmd, 8'h07};
        for (int i = 0; i < 8; i++) q.push_back(m[8*i +: 8]);
        q.push_back(eof);
        return q;
    endfunction

    task automatic send_bytes(input bq_t fr, input int from, input int upto, input bit rgap);
        for (int i = from; i < upto; i++) begin
            bus.i_rx_data = fr[i];
            bus.i_rx_vld  = 1'b1;
            tick();
            bus.i_rx_vld = 1'b0;
            if (rgap) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic run_frame(input bq_t fr, input int skip, input bit hold,
                             input bit rgap, input string tag);
        exp_t        e;
        int          t0;
        int          s0;
        logic [63:0] en_before;
        bit          exp_stb;
        e         = model(fr);
        t0        = tx_cnt;
        s0        = stb_cycles;
        en_before = exp_en;
        if (hold) bus.i_tx_busy = 1'b1;
        send_bytes(fr, skip, e.n_send, rgap);
        if (hold) begin
            repeat (6) tick();
            chk({tag, "_busy_wait"}, 64'(tx_cnt - t0), 64'd0);
            bus.i_tx_busy = 1'b0;
        end
        for (int i = 0; i < 40 && tx_cnt == t0; i++) tick();
        repeat (2) tick();
        chk({tag, "_tx_count"}, 64'(tx_cnt - t0), 64'd1);
        chk({tag, "_tx_byte"}, 64'(last_tx), 64'(e.tx));
        exp_stb = (e.kind == K_INIT) ||
                  (((e.kind == K_INC) || (e.kind == K_DEC)) && (e.val != 0));
        chk({tag, "_strobe_cycles"}, 64'(stb_cycles - s0), exp_stb ? 64'd1 : 64'd0);
        if (e.kind == K_INC) begin
            chk({tag, "_inc_stb"}, last_inc, e.val);
            chk({tag, "_dec_quiet"}, last_dec, 64'd0);
        end
        if (e.kind == K_DEC) begin
            chk({tag, "_dec_stb"}, last_dec, e.val);
            chk({tag, "_inc_quiet"}, last_inc, 64'd0);
        end
        if (e.kind == K_INIT) chk({tag, "_init_vld"}, 64'(last_init_vld), 64'd1);
        if (exp_stb) chk({tag, "_strobe_latency"}, 64'(last_stb_cyc - last_vld_cyc), 64'd1);
        if (e.kind == K_EN) exp_en = e.val;
        if (e.kind == K_INIT) exp_init = e.val[7:0];
        if ((e.kind == K_EN) && (e.val != en_before))
            chk({tag, "_en_latency"}, 64'(en_chg_cyc - last_vld_cyc), 64'd1);
        chk({tag, "_en_mask"}, bus.o_en_mask, exp_en);
        chk({tag, "_init_data"}, 64'(bus.o_init_data), 64'(exp_init));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en_mask"}, bus.o_en_mask, 64'd0);
        chk({tag, "_inc_stb"}, bus.o_inc_stb, 64'd0);
        chk({tag, "_dec_stb"}, bus.o_dec_stb, 64'd0);
        chk({tag, "_init_vld"}, 64'(bus.o_init_vld), 64'd0);
        chk({tag, "_init_data"}, 64'(bus.o_init_data), 64'd0);
        chk({tag, "_tx_start"}, 64'(bus.o_tx_start), 64'd0);
        chk({tag, "_tx_data"}, 64'(bus.o_tx_data), 64'd0);
    endtask

    initial begin
        bq_t         fr;
        int          t0;
        logic [7:0]  cmd;
        logic [7:0]  want;
        logic [7:0]  len;
        logic [63:0] rmask;

        bus.i_rx_data = '0;
        bus.i_rx_vld  = 1'b0;
        bus.i_tx_busy = 1'b0;
        rst           = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        fr = {8'h4B, 8'h00, 8'h00, 8'h45, 8'h0D};
        run_frame(fr, 0, 1'b0, 1'b0, "init45");
        chk("init45_value", 64'(bus.o_init_data), 64'h45);
        chk("init45_ack", 64'(last_tx), 64'h06);

        run_frame(mask_frame(8'h02, 64'h00000000050000F1, 8'h0D), 0, 1'b0, 1'b0, "enable");
        chk("enable_value", bus.o_en_mask, 64'h00000000050000F1);

        run_frame(mask_frame(8'h0A, 64'h00000000050000F1, 8'h0D), 0, 1'b0, 1'b0, "inc");
        run_frame(mask_frame(8'h12, 64'h00000000050000F1, 8'h0D), 0, 1'b0, 1'b0, "dec");
        chk("incdec_en_kept", bus.o_en_mask, 64'h00000000050000F1);

        fr = mask_frame(8'h0A, 64'h1122334455667788, 8'h0D);
        fr[2] = 8'h05;
        run_frame(fr, 0, 1'b0, 1'b0, "bad_len");
        run_frame(mask_frame(8'h02, 64'hDEADBEEF00C0FFEE, 8'h0E), 0, 1'b0, 1'b0, "bad_eof");
        run_frame(mask_frame(8'h33, 64'h0, 8'h0D), 0, 1'b0, 1'b0, "bad_cmd");
        chk("nak_en_kept", bus.o_en_mask, 64'h00000000050000F1);

        run_frame({8'h4B, 8'h00, 8'h00, 8'h5A, 8'h0D}, 0, 1'b1, 1'b0, "busy");

        t0 = tx_cnt;
        send_bytes({8'h00, 8'h0D, 8'h12, 8'hFF, 8'h06}, 0, 5, 1'b0);
        repeat (10) tick();
        chk("idle_discard_no_tx", 64'(tx_cnt - t0), 64'd0);
        run_frame(mask_frame(8'h0A, 64'h8000000000000001, 8'h0D), 0, 1'b0, 1'b0, "after_noise");

        // stall after three payload bytes
        fr = mask_frame(8'h02, 64'h0123456789ABCDEF, 8'h0D);
        t0 = tx_cnt;
        send_bytes(fr, 0, 6, 1'b0);
`ifdef FRAME_CTRL_TIMEOUT_EN
        repeat (TMO + 10) tick();
        chk("timeout_no_tx", 64'(tx_cnt - t0), 64'd0);
        chk("timeout_en_kept", bus.o_en_mask, exp_en);
        run_frame(fr, 0, 1'b0, 1'b0, "after_timeout");
        // byte arriving in the very last idle cycle must keep the frame
        fr = mask_frame(8'h02, 64'h00FF00FF00FF00FF, 8'h0D);
        send_bytes(fr, 0, 6, 1'b0);
        repeat (TMO - 1) tick();
        run_frame(fr, 6, 1'b0, 1'b0, "expiry_edge");
`else
        repeat (TMO + 10) tick();
        chk("stall_no_tx", 64'(tx_cnt - t0), 64'd0);
        run_frame(fr, 6, 1'b0, 1'b0, "resume");
`endif

        fr = mask_frame(8'h02, 64'h5555AAAA5555AAAA, 8'h0D);
        send_bytes(fr, 0, 7, 1'b0);
        rst = 1'b1;
        tick();
        chk_reset_outputs("midreset");
        rst      = 1'b0;
        exp_en   = '0;
        exp_init = '0;
        t0       = tx_cnt;
        repeat (20) tick();
        chk("midreset_no_tx", 64'(tx_cnt - t0), 64'd0);
        run_frame(mask_frame(8'h02, 64'h0F0F0F0F0F0F0F0F, 8'h0D), 0, 1'b0, 1'b0, "post_reset");

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       cmd = 8'h00;
                1:       cmd = 8'h02;
                2:       cmd = 8'h0A;
                3:       cmd = 8'h12;
                default: cmd = 8'($urandom_range(0, 255));
            endcase
            want  = (cmd == 8'h00) ? 8'h00 : 8'h07;
            len   = ($urandom_range(0, 9) < 8) ? want : 8'($urandom_range(0, 255));
            rmask = {$urandom(), $urandom()};
            fr    = {8'h4B, cmd, len};
            for (int i = 0; i <= int'(want); i++) fr.push_back(rmask[8*i +: 8]);
            fr.push_back(($urandom_range(0, 4) != 0) ? 8'h0D : 8'($urandom_range(0, 255)));
            run_frame(fr, 0, ($urandom_range(0, 3) == 0), 1'b1, $sformatf("rnd%0d", n));
        end

        chk("tx_start_while_busy", 64'(busy_viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pwm_cmd_ctrl.md
PWM_CMD_CTRL -- requirements
Module: pwm_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter g_NUM_CH, default 64, giving the number of PWM channels; it SHALL equal 8*(mask payload bytes).
REQ-002 The block SHALL have parameter g_TIMEOUT_CYC, default 30000, giving the maximum idle clock cycles between bytes of one frame.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset; no other clock or reset exists.
REQ-004 Port i_clk: input, 1 bit, the system clock.
REQ-005 Port i_rst: input, 1 bit, synchronous active-high reset.
REQ-006 Port i_rx_data: input, 8 bits, byte received from the UART.
REQ-007 Port i_rx_vld: input, 1 bit, one-cycle qualifier for i_rx_data.
REQ-008 Port o_tx_data: output, 8 bits, response byte to the UART.
REQ-009 Port o_tx_start: output, 1 bit, one-cycle transmit request.
REQ-010 Port i_tx_busy: input, 1 bit, UART transmitter busy.
REQ-011 Port o_en_mask: output, g_NUM_CH bits, registered channel enable mask.
REQ-012 Port o_inc_stb: output, g_NUM_CH bits, one-cycle per-channel increment pulses.
REQ-013 Port o_dec_stb: output, g_NUM_CH bits, one-cycle per-channel decrement pulses.
REQ-014 Port o_init_vld: output, 1 bit, one-cycle init command pulse.
REQ-015 Port o_init_data: output, 8 bits, init payload byte, held until the next INIT.

Function
REQ-016 Frame format SHALL be: SOF 0x4B, CMD, LEN, LEN+1 payload bytes, EOF 0x0D.
REQ-017 Commands SHALL be: 0x00 INIT (LEN 0x00), 0x02 ENABLE (LEN 0x07), 0x0A INC (LEN 0x07), 0x12 DEC (LEN 0x07).
REQ-018 FSM states SHALL be IDLE, CMD, LEN, PAYLOAD, EOF, EXEC, RESP; each transition out of CMD/LEN/PAYLOAD/EOF is taken only on i_rx_vld.
REQ-019 In IDLE, bytes other than 0x4B SHALL be discarded silently; 0x4B moves to CMD.
REQ-020 An unknown CMD, or a LEN not matching REQ-017, SHALL queue NAK 0x15 and go to RESP without entering PAYLOAD.
REQ-021 Payload byte i (0-based) SHALL be stored in bits [8i+7:8i] (little-endian).
REQ-022 A byte other than 0x0D in EOF SHALL queue NAK and cause no output change.
REQ-023 A valid EOF SHALL enter EXEC for exactly one cycle: ENABLE loads o_en_mask; INC/DEC pulse o_inc_stb/o_dec_stb with the mask; INIT loads o_init_data and pulses o_init_vld; ACK 0x06 is then queued.
REQ-024 Latency from the EOF i_rx_vld cycle to the EXEC outputs SHALL be exactly 2 cycles.
REQ-025 In RESP, o_tx_start SHALL pulse for one cycle in the first cycle with i_tx_busy low, with o_tx_data stable; the FSM then returns to IDLE.
REQ-026 Bytes arriving in EXEC or RESP SHALL be dropped.
REQ-027 Strobe outputs SHALL be zero in every cycle except EXEC.

Reset
REQ-028 Reset SHALL force IDLE, o_en_mask=0, strobes=0, o_init_vld=0, o_init_data=0, o_tx_start=0, o_tx_data=0, and the timeout counter=0.
REQ-029 Reset mid-frame SHALL discard the partial frame with no response.

Configuration
REQ-030 With FRAME_CTRL_TIMEOUT_EN defined, g_TIMEOUT_CYC cycles without i_rx_vld in CMD/LEN/PAYLOAD/EOF SHALL abort to IDLE with no response; the counter clears on every i_rx_vld, and a byte in the expiry cycle wins.
REQ-031 Without FRAME_CTRL_TIMEOUT_EN, no timeout logic SHALL exist and the FSM waits indefinitely.

Structure
REQ-032 Package pwm_cmd_pkg SHALL hold the SOF/EOF/ACK/NAK constants, command codes, expected LEN values and the FSM state enum.
REQ-033 The inter-byte timeout SHALL be a sub-module frame_timeout, instantiated only when FRAME_CTRL_TIMEOUT_EN is defined.

Verification
REQ-034 Send 4B 00 00 45 0D -> o_init_vld pulse, o_init_data=0x45, tx 0x06.
REQ-035 Send ENABLE with mask 0x00000000050000F1 -> o_en_mask=0x00000000050000F1 2 cycles after EOF, tx 0x06.
REQ-036 Send INC, then DEC, with the same mask -> a single-cycle strobe equal to the mask on the correct port, o_en_mask unchanged.
REQ-037 Send 4B 0A 05 ... , then 4B 02 07 + 8 bytes + 0x0E -> tx 0x15 for each, no output change.
REQ-038 Stop after 3 payload bytes (macro defined) -> return to IDLE after g_TIMEOUT_CYC cycles with no tx; a following valid frame is ACKed.
REQ-039 Hold i_tx_busy high in RESP -> o_tx_start waits for busy low; assert i_rst mid-payload -> all outputs at reset values.
